// File: rtl/gv_out_pkg.sv
// Shared types for the game-output pin drivers.
package gv_out_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } blink_state_t;

endpackage

// File: rtl/pulse_blink_driver_blink_timer.sv
// Loadable down-counter with zero flag. Loads take effect at the next edge and take priority over counting.
// No backpressure. The counter holds at zero instead of wrapping.
module blink_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_blink_driver.sv
// One visible blink per strobe; blink_out rises one cycle after pulse_in. Strobes arriving mid-blink queue in a saturating counter.
// No backpressure: excess strobes drop at saturation. Define BLINK_OVERFLOW_FLAG_EN to flag such drops on a sticky ovf output.
module pulse_blink_driver
  import gv_out_pkg::*;
#(
  parameter int ON_CYCLES  = 1200000,
  parameter int OFF_CYCLES = 600000,
  parameter int PEND_W     = 3
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              blink_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending
`ifdef BLINK_OVERFLOW_FLAG_EN
  ,
  output logic              ovf
`endif
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  blink_state_t      state, state_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic              blink_nxt;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_en;
  logic              tmr_zero;
  logic              consume;

  blink_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    pend_nxt  = pending;
    blink_nxt = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_en    = 1'b0;
    consume   = 1'b0;

    if (clear) begin
      // Loading zero also parks the timer at its reset value.
      state_nxt = IDLE;
      pend_nxt  = '0;
      tmr_load  = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (pulse_in) begin
            state_nxt = ON;
            tmr_load  = 1'b1;
            tmr_val   = ON_LOAD;
            blink_nxt = 1'b1;
          end
        end
        ON: begin
          tmr_en    = 1'b1;
          blink_nxt = 1'b1;
          if (tmr_zero) begin
            state_nxt = GAP;
            tmr_load  = 1'b1;
            tmr_val   = OFF_LOAD;
            blink_nxt = 1'b0;
          end
        end
        GAP: begin
          tmr_en = 1'b1;
          if (tmr_zero) begin
            if ((pending != '0) || pulse_in) begin
              consume   = 1'b1;
              state_nxt = ON;
              tmr_load  = 1'b1;
              tmr_val   = ON_LOAD;
              blink_nxt = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase

      // A strobe coinciding with a consume cancels it; with nothing queued the strobe is the request itself.
      if (state != IDLE) begin
        if (consume) begin
          if (!pulse_in) begin
            pend_nxt = pending - 1'b1;
          end
        end else if (pulse_in && (pending != PEND_MAX)) begin
          pend_nxt = pending + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      pending   <= '0;
      blink_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pend_nxt;
      blink_out <= blink_nxt;
    end
  end

  assign busy = (state != IDLE);

`ifdef BLINK_OVERFLOW_FLAG_EN
  logic ovf_set;

  assign ovf_set = pulse_in && !clear && (state != IDLE) && !consume && (pending == PEND_MAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf <= 1'b0;
    end else if (clear) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_blink_driver.sv
// Cycle-by-cycle vector table for pulse_blink_driver at ON=4, OFF=2, PEND_W=2, plus a hand-written async reset sequence.
module tb_pulse_blink_driver;

  localparam int ON_C  = 4;
  localparam int OFF_C = 2;
  localparam int PW    = 2;

  typedef struct {
    logic       p;
    logic       c;
    logic       b;
    logic       bz;
    logic [1:0] pd;
    logic       ov;
  } vec_t;

  logic          clk      = 1'b0;
  logic          n_rst    = 1'b0;
  logic          pulse_in = 1'b0;
  logic          clear    = 1'b0;
  logic          blink_out;
  logic          busy;
  logic [PW-1:0] pending;
`ifdef BLINK_OVERFLOW_FLAG_EN
  logic          ovf;
`endif

  vec_t vecs[$];
  vec_t sb[$];
  int   passed = 0;
  int   total  = 0;

  pulse_blink_driver #(
    .ON_CYCLES  (ON_C),
    .OFF_CYCLES (OFF_C),
    .PEND_W     (PW)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .pulse_in  (pulse_in),
    .clear     (clear),
    .blink_out (blink_out),
    .busy      (busy),
    .pending   (pending)
`ifdef BLINK_OVERFLOW_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    chk({tag, ".blink"}, int'(blink_out), int'(e.b));
    chk({tag, ".busy"}, int'(busy), int'(e.bz));
    chk({tag, ".pending"}, int'(pending), int'(e.pd));
`ifdef BLINK_OVERFLOW_FLAG_EN
    chk({tag, ".ovf"}, int'(ovf), int'(e.ov));
`endif
  endtask

  // n identical rows: inputs for one cycle and the outputs expected after that edge.
  task automatic add(input int n, input logic p, input logic c, input logic b,
                     input logic bz, input int pd, input logic ov);
    vec_t v;
    v.p  = p;
    v.c  = c;
    v.b  = b;
    v.bz = bz;
    v.pd = 2'(pd);
    v.ov = ov;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic add_single();
    add(1, 1, 0, 1, 1, 0, 0);
    add(3, 0, 0, 1, 1, 0, 0);
    add(2, 0, 0, 0, 1, 0, 0);
    add(2, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_vectors(input string tag);
    vec_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      pulse_in = vecs[i].p;
      clear    = vecs[i].c;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_outs($sformatf("%s[%0d]", tag, i), e);
    end
    pulse_in = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    vec_t z;
    z.p = 0; z.c = 0; z.b = 0; z.bz = 0; z.pd = 2'd0; z.ov = 0;

    #12;
    check_outs("reset", z);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Single strobe
    add_single();
    // Queued strobes at rows 0, 2, 3
    add(1, 1, 0, 1, 1, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0);
    add(1, 1, 0, 1, 1, 1, 0);
    add(1, 1, 0, 1, 1, 2, 0);
    add(2, 0, 0, 0, 1, 2, 0);
    add(4, 0, 0, 1, 1, 1, 0);
    add(2, 0, 0, 0, 1, 1, 0);
    add(4, 0, 0, 1, 1, 0, 0);
    add(2, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // Strobe on the GAP-to-ON edge with pending=1
    add(1, 1, 0, 1, 1, 0, 0);
    add(1, 1, 0, 1, 1, 1, 0);
    add(2, 0, 0, 1, 1, 1, 0);
    add(2, 0, 0, 0, 1, 1, 0);
    add(1, 1, 0, 1, 1, 1, 0);
    add(3, 0, 0, 1, 1, 1, 0);
    add(2, 0, 0, 0, 1, 1, 0);
    add(4, 0, 0, 1, 1, 0, 0);
    add(2, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // Strobe on the final gap edge with pending=0
    add(1, 1, 0, 1, 1, 0, 0);
    add(3, 0, 0, 1, 1, 0, 0);
    add(2, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0);
    add(3, 0, 0, 1, 1, 0, 0);
    add(2, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // Saturation: five strobes, four blinks, the last strobe overflows
    add(1, 1, 0, 1, 1, 0, 0);
    add(1, 1, 0, 1, 1, 1, 0);
    add(1, 1, 0, 1, 1, 2, 0);
    add(1, 1, 0, 1, 1, 3, 0);
    add(1, 1, 0, 0, 1, 3, 1);
    add(1, 0, 0, 0, 1, 3, 1);
    add(4, 0, 0, 1, 1, 2, 1);
    add(2, 0, 0, 0, 1, 2, 1);
    add(4, 0, 0, 1, 1, 1, 1);
    add(2, 0, 0, 0, 1, 1, 1);
    add(4, 0, 0, 1, 1, 0, 1);
    add(2, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1);
    // Clear together with a strobe mid-ON, pending=2
    add(1, 1, 0, 1, 1, 0, 1);
    add(1, 1, 0, 1, 1, 1, 1);
    add(1, 1, 0, 1, 1, 2, 1);
    add(1, 1, 1, 0, 0, 0, 0);
    add(6, 0, 0, 0, 0, 0, 0);
    run_vectors("seq");

    // Asynchronous reset in the middle of an ON phase
    pulse_in = 1'b1;
    @(posedge clk);
    #1;
    pulse_in = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst.blink", int'(blink_out), 1);
    #2;
    n_rst = 1'b0;
    #1;
    check_outs("async_rst", z);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    vecs.delete();
    add_single();
    run_vectors("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
